// File: rtl/ps2_cmd_ctrl.sv
// PS/2 scan-code command controller.
// Parses make/break/extended prefixes from a PS/2 receiver, tracks a mask of
// six held keys, pulses press_o on new presses and samples the lowest held
// key as a one-hot command once per DIV-cycle tick.
module ps2_cmd_ctrl #(
    parameter int unsigned DIV = 1000000,
    parameter int unsigned TO  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_i,
    input  logic       code_vld_i,
    output logic [5:0] held_o,
    output logic [5:0] cmd_o,
    output logic       press_o
);

    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TOW = (TO > 1) ? $clog2(TO) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       held_q, held_d;
    logic [5:0]       cmd_q, cmd_d;
    logic             press_q, press_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [TOW-1:0]   to_cnt_q, to_cnt_d;
    logic             tick;
    logic             to_expire;
    logic             key_hit;
    logic [5:0]       key_bit;
    logic             found;

    // Translate the incoming byte into its held-mask bit, if it is a tracked key.
    always_comb begin
        key_hit = 1'b0;
        key_bit = '0;
        case (code_i)
            8'h24: begin key_hit = 1'b1; key_bit = 6'b000001; end
            8'h4B: begin key_hit = 1'b1; key_bit = 6'b000010; end
            8'h2D: begin key_hit = 1'b1; key_bit = 6'b000100; end
            8'h5A: begin key_hit = 1'b1; key_bit = 6'b001000; end
            8'h23: begin key_hit = 1'b1; key_bit = 6'b010000; end
            8'h1D: begin key_hit = 1'b1; key_bit = 6'b100000; end
            default: begin key_hit = 1'b0; key_bit = '0; end
        endcase
    end

    // Free-running tick counter and prefix timeout counter.
    always_comb begin
        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        to_expire  = (state_q != IDLE) && !code_vld_i && (to_cnt_q == TOW'(TO - 1));
        if (code_vld_i || (state_q == IDLE) || to_expire) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TOW'(1);
        end
    end

    // Prefix FSM and held-mask update; 0x00/0xFF resets everything from any state.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (code_vld_i) begin
            if ((code_i == 8'h00) || (code_i == 8'hFF)) begin
                state_d = IDLE;
                held_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (code_i == 8'hF0) begin
                            state_d = BRK;
                        end else if (code_i == 8'hE0) begin
                            state_d = EXT;
                        end else if (key_hit) begin
                            held_d = held_q | key_bit;
                        end
                    end
                    BRK: begin
                        state_d = IDLE;
                        if (key_hit) begin
                            held_d = held_q & ~key_bit;
                        end
                    end
                    EXT: begin
                        state_d = (code_i == 8'hF0) ? EXT_BRK : IDLE;
                    end
                    EXT_BRK: begin
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (to_expire) begin
            state_d = IDLE;
        end
        press_d = |(held_d & ~held_q);
    end

    // On tick, load the lowest-index held key as one-hot; uses the pre-strobe mask.
    always_comb begin
        cmd_d = cmd_q;
        found = 1'b0;
        if (tick) begin
            cmd_d = '0;
            for (int unsigned i = 0; i < 6; i++) begin
                if (!found && held_q[i]) begin
                    cmd_d[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            held_q     <= '0;
            cmd_q      <= '0;
            press_q    <= 1'b0;
            tick_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            cmd_q      <= cmd_d;
            press_q    <= press_d;
            tick_cnt_q <= tick_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign held_o  = held_q;
    assign cmd_o   = cmd_q;
    assign press_o = press_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl with DIV=4, TO=8.
// A prefix-flag behavioural model predicts held/press/cmd every cycle;
// directed scenarios add literal expectations.
module tb_ps2_cmd_ctrl;

    localparam int DIV = 4;
    localparam int TO  = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] code;
    logic       vld;
    logic [5:0] held;
    logic [5:0] cmd;
    logic       press;

    int tests = 0;
    int fails = 0;
    bit checking = 0;

    ps2_cmd_ctrl #(.DIV(DIV), .TO(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_i     (code),
        .code_vld_i (vld),
        .held_o     (held),
        .cmd_o      (cmd),
        .press_o    (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [5:0] m_held;
    logic [5:0] m_cmd;
    logic       m_press;
    int         m_tick;
    int         m_idle;
    bit         m_brk;
    bit         m_ext;
    logic [7:0] keys [6] = '{8'h24, 8'h4B, 8'h2D, 8'h5A, 8'h23, 8'h1D};

    function automatic int key_index(input logic [7:0] c);
        for (int k = 0; k < 6; k++) if (keys[k] == c) return k;
        return -1;
    endfunction

    function automatic logic [5:0] lowest(input logic [5:0] m);
        for (int k = 0; k < 6; k++) if (m[k]) return 6'(1) << k;
        return 6'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [5:0] nh;
        int ki;
        if (!rst_n) begin
            m_held = 0; m_cmd = 0; m_press = 0;
            m_tick = 0; m_idle = 0; m_brk = 0; m_ext = 0;
        end else begin
            nh = m_held;
            if (m_tick == DIV - 1) m_cmd = lowest(m_held);
            m_tick = (m_tick + 1) % DIV;
            if (vld) begin
                ki = key_index(code);
                m_idle = 0;
                if (code == 8'h00 || code == 8'hFF) begin
                    nh = 0; m_brk = 0; m_ext = 0;
                end else if (m_ext) begin
                    if (!m_brk && code == 8'hF0) m_brk = 1;
                    else begin m_brk = 0; m_ext = 0; end
                end else if (m_brk) begin
                    if (ki >= 0) nh[ki] = 1'b0;
                    m_brk = 0;
                end else if (code == 8'hF0) m_brk = 1;
                else if (code == 8'hE0) m_ext = 1;
                else if (ki >= 0) nh[ki] = 1'b1;
            end else if (m_brk || m_ext) begin
                m_idle++;
                if (m_idle >= TO) begin m_brk = 0; m_ext = 0; m_idle = 0; end
            end
            m_press = |(nh & ~m_held);
            m_held  = nh;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("model_held", {2'b00, held}, {2'b00, m_held});
            chk("model_cmd", {2'b00, cmd}, {2'b00, m_cmd});
            chk("model_press", {7'd0, press}, {7'd0, m_press});
        end
    end

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        code = c;
        vld  = 1'b1;
        @(negedge clk);
        vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 19);
        if (r < 9) return keys[$urandom_range(0, 5)];
        if (r < 13) return 8'hF0;
        if (r < 16) return 8'hE0;
        if (r == 16) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        code  = 8'h00;
        vld   = 1'b0;
        #1;
        chk("reset_held", {2'b00, held}, 8'h00);
        chk("reset_cmd", {2'b00, cmd}, 8'h00);
        chk("reset_press", {7'd0, press}, 8'h00);
        // strobes during reset are ignored
        @(negedge clk); code = 8'h24; vld = 1'b1;
        @(negedge clk); vld = 1'b0;
        chk("reset_ignores_strobe", {2'b00, held}, 8'h00);
        #2 rst_n = 1'b1;
        checking = 1;

        // single make
        send(8'h24);
        chk("make24_held", {2'b00, held}, 8'h01);
        chk("make24_press", {7'd0, press}, 8'h01);
        idle(DIV);
        chk("make24_cmd", {2'b00, cmd}, 8'h01);
        send(8'hFF);

        // two keys, release the winner
        send(8'h5A);
        chk("5A_held", {2'b00, held}, 8'h08);
        chk("5A_press", {7'd0, press}, 8'h01);
        send(8'h4B);
        chk("4B_held", {2'b00, held}, 8'h0A);
        chk("4B_press", {7'd0, press}, 8'h01);
        idle(DIV);
        chk("two_cmd", {2'b00, cmd}, 8'h02);
        send(8'hF0);
        send(8'h4B);
        chk("brk4B_held", {2'b00, held}, 8'h08);
        chk("brk4B_press", {7'd0, press}, 8'h00);
        idle(DIV);
        chk("after_brk_cmd", {2'b00, cmd}, 8'h08);
        send(8'hFF);

        // extended keys are never tracked
        send(8'hE0); send(8'h24);
        chk("ext_make_held", {2'b00, held}, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h24);
        chk("ext_brk_held", {2'b00, held}, 8'h00);
        chk("ext_brk_press", {7'd0, press}, 8'h00);
        send(8'h24);
        chk("ext_back_idle", {2'b00, held}, 8'h01);
        send(8'hFF);

        // prefix timeout
        send(8'hF0);
        idle(TO);
        send(8'h24);
        chk("timeout_held", {2'b00, held}, 8'h01);
        chk("timeout_press", {7'd0, press}, 8'h01);
        send(8'hFF);

        // clear by 0xFF, typematic repeat
        send(8'h5A); send(8'h1D);
        chk("mask_101000", {2'b00, held}, 8'h28);
        send(8'hFF);
        chk("ff_clear", {2'b00, held}, 8'h00);
        idle(DIV);
        chk("ff_cmd", {2'b00, cmd}, 8'h00);
        send(8'h1D);
        chk("1D_first_press", {7'd0, press}, 8'h01);
        send(8'h1D);
        chk("1D_repeat_press", {7'd0, press}, 8'h00);
        chk("1D_repeat_held", {2'b00, held}, 8'h20);
        send(8'hFF);

        // reset mid-prefix
        send(8'h24);
        send(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_held", {2'b00, held}, 8'h00);
        chk("midreset_cmd", {2'b00, cmd}, 8'h00);
        chk("midreset_press", {7'd0, press}, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'h24);
        chk("postreset_held", {2'b00, held}, 8'h01);
        chk("postreset_press", {7'd0, press}, 8'h01);

        // randomized traffic, including back-to-back strobes and long gaps
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) begin
                vld = 1'b0;
                repeat ($urandom_range(TO - 2, TO + 3)) @(negedge clk);
            end
            if ($urandom_range(0, 2) == 0) begin
                code = pick();
                vld  = 1'b1;
            end else begin
                code = 8'($urandom_range(0, 255));
                vld  = 1'b0;
            end
        end
        @(negedge clk);
        vld = 1'b0;
        idle(2);
        checking = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
